// File: rtl/spi_pkg.sv
// Shared types and SPI mode constants for the SPI slave endpoint.
// Mode 0 only: sclk idles low, data is sampled on rise and shifted on fall, MSB first.
package spi_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_slave_state_e;

  localparam logic SPI_CPOL      = 1'b0;
  localparam logic SPI_CPHA      = 1'b0;
  localparam logic SPI_MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses
// derived from the last synchronizer stage.
module spi_sync_edge #(
  parameter int   SyncStages = 2,
  parameter logic ResetVal   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SyncStages-1:0] chain_r;
  logic                  prev_r;

  // Synchronizer chain plus one delay flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= {SyncStages{ResetVal}};
      prev_r  <= ResetVal;
    end else begin
      chain_r <= {chain_r[SyncStages-2:0], din};
      prev_r  <= chain_r[SyncStages-1];
    end
  end

  assign sync = chain_r[SyncStages-1];
  assign rise = sync & ~prev_r;
  assign fall = ~sync & prev_r;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave endpoint: oversampled sclk/mosi/nss, one rx and one tx word
// per DataWidth bits, with a single-entry transmit holding register.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DataWidth  = 8,
  parameter int SyncStages = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 nss,
  output logic                 miso,
  input  logic [DataWidth-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DataWidth-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 tx_underrun
);

  localparam int CntW = (DataWidth > 2) ? $clog2(DataWidth) : 1;
  localparam logic [CntW-1:0] LAST_BIT = CntW'(DataWidth - 1);

  logic sclk_level_unused, sclk_rise_s, sclk_fall_s;
  logic mosi_sync_s, mosi_rise_unused, mosi_fall_unused;
  logic nss_level_unused, nss_rise_s, nss_fall_s;

  spi_sync_edge #(.SyncStages(SyncStages), .ResetVal(SPI_CPOL)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .sync(sclk_level_unused), .rise(sclk_rise_s), .fall(sclk_fall_s));

  spi_sync_edge #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .sync(mosi_sync_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  spi_sync_edge #(.SyncStages(SyncStages), .ResetVal(1'b1)) u_sync_nss (
    .clk(clk), .rst_n(rst_n), .din(nss),
    .sync(nss_level_unused), .rise(nss_rise_s), .fall(nss_fall_s));

  spi_slave_state_e     state_r, state_nx;
  logic [CntW-1:0]      bit_cnt_r, bit_cnt_nx;
  logic                 word_done_r, word_done_nx;
  logic [DataWidth-1:0] tx_shift_r, tx_shift_nx;
  logic [DataWidth-1:0] rx_shift_r, rx_shift_nx;
  logic [DataWidth-1:0] hold_r, hold_nx;
  logic                 hold_empty_r, hold_empty_nx;
  logic [DataWidth-1:0] rx_data_r, rx_data_nx;
  logic                 rx_valid_r, rx_valid_nx;
  logic                 frame_err_r, frame_err_nx;
  logic                 tx_underrun_r, tx_underrun_nx;
  logic                 miso_r, miso_nx;
  logic                 busy_r, busy_nx;
  logic                 reload_s;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      bit_cnt_r     <= '0;
      word_done_r   <= 1'b0;
      tx_shift_r    <= '0;
      rx_shift_r    <= '0;
      hold_r        <= '0;
      hold_empty_r  <= 1'b1;
      rx_data_r     <= '0;
      rx_valid_r    <= 1'b0;
      frame_err_r   <= 1'b0;
      tx_underrun_r <= 1'b0;
      miso_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nx;
      bit_cnt_r     <= bit_cnt_nx;
      word_done_r   <= word_done_nx;
      tx_shift_r    <= tx_shift_nx;
      rx_shift_r    <= rx_shift_nx;
      hold_r        <= hold_nx;
      hold_empty_r  <= hold_empty_nx;
      rx_data_r     <= rx_data_nx;
      rx_valid_r    <= rx_valid_nx;
      frame_err_r   <= frame_err_nx;
      tx_underrun_r <= tx_underrun_nx;
      miso_r        <= miso_nx;
      busy_r        <= busy_nx;
    end
  end

  // Next-state, shift-register and holding-register logic
  always_comb begin
    state_nx       = state_r;
    bit_cnt_nx     = bit_cnt_r;
    word_done_nx   = word_done_r;
    tx_shift_nx    = tx_shift_r;
    rx_shift_nx    = rx_shift_r;
    hold_nx        = hold_r;
    hold_empty_nx  = hold_empty_r;
    rx_data_nx     = rx_data_r;
    rx_valid_nx    = 1'b0;
    frame_err_nx   = 1'b0;
    tx_underrun_nx = 1'b0;
    reload_s       = 1'b0;

    case (state_r)
      IDLE: begin
        if (nss_fall_s) begin
          state_nx     = ACTIVE;
          reload_s     = 1'b1;
          bit_cnt_nx   = '0;
          word_done_nx = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
      ACTIVE: begin
        if (sclk_rise_s) begin
          rx_shift_nx = {rx_shift_r[DataWidth-2:0], mosi_sync_s};
          if (bit_cnt_r == LAST_BIT) begin
            rx_data_nx   = rx_shift_nx;
            rx_valid_nx  = 1'b1;
            bit_cnt_nx   = '0;
            word_done_nx = 1'b1;
          end else begin
            bit_cnt_nx = bit_cnt_r + CntW'(1);
          end
        end else if (sclk_fall_s) begin
          if (word_done_r) begin
            reload_s     = 1'b1;
            word_done_nx = 1'b0;
          end else begin
            tx_shift_nx = {tx_shift_r[DataWidth-2:0], 1'b0};
          end
        end else begin
          tx_shift_nx = tx_shift_r;
        end
        // The sclk rise above is already folded into bit_cnt_nx here
        if (nss_rise_s) begin
          state_nx     = IDLE;
          frame_err_nx = (bit_cnt_nx != '0);
          bit_cnt_nx   = '0;
          word_done_nx = 1'b0;
        end else begin
          state_nx = ACTIVE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (reload_s) begin
      if (!hold_empty_r) begin
        tx_shift_nx = hold_r;
      end else begin
        tx_shift_nx    = '0;
        tx_underrun_nx = 1'b1;
      end
    end else begin
      tx_underrun_nx = 1'b0;
    end

    // Load requires an empty register, so it never collides with a drain
    if (tx_valid && hold_empty_r) begin
      hold_nx       = tx_data;
      hold_empty_nx = 1'b0;
    end else if (reload_s && !hold_empty_r) begin
      hold_empty_nx = 1'b1;
    end else begin
      hold_empty_nx = hold_empty_r;
    end

    miso_nx = (state_nx == ACTIVE) ? tx_shift_nx[DataWidth-1] : 1'b0;
    busy_nx = (state_nx == ACTIVE);
  end

  assign miso        = miso_r;
  assign tx_ready    = hold_empty_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign busy        = busy_r;
  assign frame_err   = frame_err_r;
  assign tx_underrun = tx_underrun_r;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural mode-0 master at sclk = clk/8
// with hand-computed expected words and pulse counts.
module tb_spi_slave;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       nss = 1'b1;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       tx_underrun;

  int checks = 0;
  int failures = 0;
  int rx_cnt = 0;
  int ferr_cnt = 0;
  int urun_cnt = 0;
  logic [7:0] rx_log[$];

  spi_slave #(.DataWidth(8), .SyncStages(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .nss(nss), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .frame_err(frame_err), .tx_underrun(tx_underrun));

  always #5 clk = ~clk;

  // Pulse monitor sampled away from the active edge
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt <= rx_cnt + 1;
      rx_log.push_back(rx_data);
    end
    if (frame_err)   ferr_cnt <= ferr_cnt + 1;
    if (tx_underrun) urun_cnt <= urun_cnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_h(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("load_ready", {15'd0, tx_ready}, 16'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic begin_frame();
    nss = 1'b0;
    wait_h(H);
  endtask

  // Master leaves sclk high after the last rise and deselects before it falls
  task automatic end_frame();
    nss = 1'b1;
    wait_h(H);
    sclk = 1'b0;
    mosi = 1'b0;
    wait_h(H);
  endtask

  task automatic shift(input logic [15:0] mo, input int nbits, output logic [15:0] mi);
    mi = 16'h0000;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[nbits-1-i];
      wait_h(H);
      sclk = 1'b1;
      mi = {mi[14:0], miso};
      wait_h(H);
      if (i < nbits - 1) sclk = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] mi;
    int rx0, fe0, ur0;

    // Reset state
    wait_h(3);
    chk("rst_miso",     {15'd0, miso},        16'd0);
    chk("rst_tx_ready", {15'd0, tx_ready},    16'd1);
    chk("rst_rx_data",  {8'd0, rx_data},      16'd0);
    chk("rst_rx_valid", {15'd0, rx_valid},    16'd0);
    chk("rst_busy",     {15'd0, busy},        16'd0);
    chk("rst_ferr",     {15'd0, frame_err},   16'd0);
    chk("rst_urun",     {15'd0, tx_underrun}, 16'd0);
    rst_n = 1'b1;
    wait_h(2);

    // Single frame
    rx0 = rx_cnt; fe0 = ferr_cnt; ur0 = urun_cnt;
    load(8'hA5);
    chk("single_tx_ready_low", {15'd0, tx_ready}, 16'd0);
    begin_frame();
    chk("single_busy", {15'd0, busy}, 16'd1);
    shift(16'h003C, 8, mi);
    end_frame();
    chk("single_miso_word", mi, 16'h00A5);
    chk("single_rx_cnt", 16'(rx_cnt - rx0), 16'd1);
    chk("single_rx_data", {8'd0, rx_data}, 16'h003C);
    chk("single_tx_ready", {15'd0, tx_ready}, 16'd1);
    chk("single_urun", 16'(urun_cnt - ur0), 16'd0);
    chk("single_ferr", 16'(ferr_cnt - fe0), 16'd0);
    chk("single_busy_end", {15'd0, busy}, 16'd0);

    // Back-to-back words with nss held low
    rx0 = rx_cnt; ur0 = urun_cnt;
    load(8'h12);
    begin_frame();
    load(8'h34);
    shift(16'hF00F, 16, mi);
    end_frame();
    chk("b2b_miso_words", mi, 16'h1234);
    chk("b2b_rx_cnt", 16'(rx_cnt - rx0), 16'd2);
    chk("b2b_rx_first", {8'd0, rx_log[rx_log.size()-2]}, 16'h00F0);
    chk("b2b_rx_second", {8'd0, rx_log[rx_log.size()-1]}, 16'h000F);
    chk("b2b_urun", 16'(urun_cnt - ur0), 16'd0);

    // Underrun
    rx0 = rx_cnt; ur0 = urun_cnt;
    begin_frame();
    chk("urun_pulse_at_fall", 16'(urun_cnt - ur0), 16'd1);
    shift(16'h0096, 8, mi);
    end_frame();
    chk("urun_miso_zero", mi, 16'h0000);
    chk("urun_cnt", 16'(urun_cnt - ur0), 16'd1);
    chk("urun_rx_cnt", 16'(rx_cnt - rx0), 16'd1);
    chk("urun_rx_data", {8'd0, rx_data}, 16'h0096);

    // Abort after 5 bits, then a clean frame
    rx0 = rx_cnt; fe0 = ferr_cnt;
    load(8'h5A);
    begin_frame();
    shift(16'h0016, 5, mi);
    end_frame();
    chk("abort_miso_bits", mi, 16'h000B);
    chk("abort_ferr", 16'(ferr_cnt - fe0), 16'd1);
    chk("abort_rx_cnt", 16'(rx_cnt - rx0), 16'd0);
    chk("abort_rx_data", {8'd0, rx_data}, 16'h0096);
    load(8'hC3);
    begin_frame();
    shift(16'h0069, 8, mi);
    end_frame();
    chk("after_abort_miso", mi, 16'h00C3);
    chk("after_abort_rx_cnt", 16'(rx_cnt - rx0), 16'd1);
    chk("after_abort_rx_data", {8'd0, rx_data}, 16'h0069);
    chk("after_abort_ferr", 16'(ferr_cnt - fe0), 16'd1);

    // Reset mid-frame
    load(8'hAA);
    begin_frame();
    shift(16'h0005, 3, mi);
    rst_n = 1'b0;
    #1;
    chk("midrst_miso",     {15'd0, miso},        16'd0);
    chk("midrst_tx_ready", {15'd0, tx_ready},    16'd1);
    chk("midrst_rx_data",  {8'd0, rx_data},      16'd0);
    chk("midrst_rx_valid", {15'd0, rx_valid},    16'd0);
    chk("midrst_busy",     {15'd0, busy},        16'd0);
    chk("midrst_ferr",     {15'd0, frame_err},   16'd0);
    chk("midrst_urun",     {15'd0, tx_underrun}, 16'd0);
    nss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_h(3);
    rst_n = 1'b1;
    wait_h(2);
    rx0 = rx_cnt;
    load(8'h81);
    begin_frame();
    shift(16'h0081, 8, mi);
    end_frame();
    chk("postrst_miso", mi, 16'h0081);
    chk("postrst_rx_cnt", 16'(rx_cnt - rx0), 16'd1);
    chk("postrst_rx_data", {8'd0, rx_data}, 16'h0081);

    // sclk toggling while deselected
    rx0 = rx_cnt; fe0 = ferr_cnt;
    for (int i = 0; i < 16; i++) begin
      mosi = i[0];
      sclk = 1'b1;
      wait_h(H);
      chk("idle_miso", {15'd0, miso}, 16'd0);
      chk("idle_busy", {15'd0, busy}, 16'd0);
      sclk = 1'b0;
      wait_h(H);
    end
    chk("idle_rx_cnt", 16'(rx_cnt - rx0), 16'd0);
    chk("idle_ferr", 16'(ferr_cnt - fe0), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
